// File: rtl/lsu_rmw_ctrl_pkg.sv
// Shared LSU defines (reset/write polarity, funct3 codes, FSM encodings) and the
// lsu_rmw_ctrl package with the captured-request type and funct3 decode helpers.
`ifndef RST
`define RST 1'b1
`endif
`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LSU_F3_B
`define LSU_F3_B  3'b000
`define LSU_F3_H  3'b001
`define LSU_F3_W  3'b010
`define LSU_F3_BU 3'b100
`define LSU_F3_HU 3'b101
`endif
`ifndef LSU_IDLE
`define LSU_IDLE 2'd0
`define LSU_RD   2'd1
`define LSU_WR   2'd2
`define LSU_RESP 2'd3
`endif

package lsu_rmw_ctrl_pkg;

  localparam logic [1:0] S_IDLE = `LSU_IDLE;
  localparam logic [1:0] S_RD   = `LSU_RD;
  localparam logic [1:0] S_WR   = `LSU_WR;
  localparam logic [1:0] S_RESP = `LSU_RESP;

  localparam logic [2:0] F3_B  = `LSU_F3_B;
  localparam logic [2:0] F3_H  = `LSU_F3_H;
  localparam logic [2:0] F3_W  = `LSU_F3_W;
  localparam logic [2:0] F3_BU = `LSU_F3_BU;
  localparam logic [2:0] F3_HU = `LSU_F3_HU;

  typedef struct packed {
    logic                   we;
    logic [2:0]             f3;
    logic [1:0]             off;
    logic [`DATA_WIDTH-1:0] wdata;
  } lsu_req_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Offending low bits are dropped so halves and words stay naturally aligned.
  function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rmw_ctrl_lane.sv
// lsu_lane: byte/half lane extraction with sign/zero extension for loads, and
// byte/half insertion into an existing word for sub-word stores.
module lsu_lane
  import lsu_rmw_ctrl_pkg::*;
(
  input  logic [1:0]             off_i,
  input  logic [2:0]             f3_i,
  input  logic [`DATA_WIDTH-1:0] word_i,
  input  logic [`DATA_WIDTH-1:0] wdata_i,
  output logic [`DATA_WIDTH-1:0] load_o,
  output logic [`DATA_WIDTH-1:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{off_i, 3'b000} +: 8];
  assign half_sel = word_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    load_o = word_i;
    case (f3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    store_o = word_i;
    case (f3_i[1:0])
      2'b00:   store_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      2'b01:   store_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// Load/store controller mapping RISC-V byte/half/word accesses onto a word memory,
// using read-modify-write for SB/SH. Define LSU_MISALIGN_EXC_EN to reject misaligned H/W.
module lsu_rmw_ctrl
  import lsu_rmw_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [ADDR_W-3:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              in_rst;
  logic              reject;
  logic              mem_active;
  logic [DATA_W-1:0] lane_word, lane_load, lane_store;

  assign in_rst = (rst == `RST);

`ifdef LSU_MISALIGN_EXC_EN
  assign reject = !f3_legal(req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign reject = !f3_legal(req_funct3);
`endif

  // Loads extract straight from memory in RD; stores merge into the word held from RD.
  assign lane_word = (state_q == S_RD) ? mem_rdata : old_q;

  lsu_lane u_lane (
    .off_i   (req_q.off),
    .f3_i    (req_q.f3),
    .word_i  (lane_word),
    .wdata_i (req_q.wdata),
    .load_o  (lane_load),
    .store_o (lane_store)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    waddr_d = waddr_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d   = '{we: req_we, f3: req_funct3,
                      off: lane_offset(req_funct3, req_addr[1:0]), wdata: req_wdata};
          waddr_d = req_addr[ADDR_W-1:2];
          if (reject) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (req_q.we) begin
          old_d   = mem_rdata;
          state_d = S_WR;
        end else begin
          rdata_d = lane_load;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      waddr_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      waddr_q <= waddr_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Everything memory-facing is gated by rst so an aborted WR cannot write.
  assign mem_active = ((state_q == S_RD) || (state_q == S_WR)) && !in_rst;
  assign req_ready  = (state_q == S_IDLE) && !in_rst;
  assign resp_valid = (state_q == S_RESP) && !in_rst;
  assign resp_rdata = in_rst ? '0 : rdata_q;
  assign resp_err   = in_rst ? 1'b0 : err_q;
  assign mem_rw     = ((state_q == S_WR) && !in_rst) ? `WRITE_ENABLE : ~`WRITE_ENABLE;
  assign mem_addr   = mem_active ? {waddr_q, 2'b00} : '0;
  assign mem_wdata  = ((state_q == S_WR) && !in_rst) ? lane_store : '0;

endmodule
